issue_select: RTL
=================

# issue_select

Parametrised oldest-first issue scheduler for the scoreboard back end. It holds one pending instruction per functional-unit slot and tracks each one's source dependency tags. Writeback broadcasts clear those tags, and the scheduler selects up to `ISSUE_W` ready instructions per cycle by age. It flushes speculative entries on a branch miss and drives registered per-FU enables and payloads into execute. It generalises the fixed five-unit issue stage to N slots, M sources, multi-issue and configurable speculation blocking.

## Interface
- `NUM_FU`, 5, number of functional-unit slots
- `NUM_SRC`, 3, dependency tags per entry
- `TAG_W`, 5, tag width; tag value 0 means "no dependency"
- `AGE_W`, 6, per-slot age counter width (saturating)
- `ISSUE_W`, 1, maximum issues per cycle (1..`NUM_FU`)
- `PAYLOAD_W`, 64, opaque decoded-op payload width
- `SPEC_BLOCK`, 5'b11010, per-slot mask; a set bit means a speculative entry may not issue until resolved
- `CLK` in 1: single clock.
- `nRST` in 1: asynchronous, active-low reset.
- `disp_valid` in 1: dispatch request.
- `disp_fu` in `$clog2(NUM_FU)`: target slot.
- `disp_tags` in `NUM_SRC*TAG_W`: source tags.
- `disp_spec` in 1: the instruction is under an unresolved branch.
- `disp_payload` in `PAYLOAD_W`: opaque payload.
- `wb_valid` in 1 and `wb_tag` in `TAG_W`: writeback broadcast.
- `fu_done` in `NUM_FU`: the FU has finished its EX entry.
- `branch_miss` in 1: flush all speculative entries.
- `branch_resolved` in 1: clear the `spec` bit on all entries.
- `issue_stall` in 1: execute cannot accept issues this cycle.
- `slot_free` out `NUM_FU`: combinational; the slot can accept a dispatch this cycle.
- `slot_state` out `2*NUM_FU`: registered state of each slot.
- `issue_en` out `NUM_FU`: registered one-cycle pulse; at most `ISSUE_W` bits are set.
- `issue_payload` out `NUM_FU*PAYLOAD_W`: registered; valid while the matching `issue_en` bit is high.
- `disp_err` out 1: sticky; a dispatch targeted a non-free slot.

## Operation
- Slot states:
  - `EMPTY`: no entry held.
  - `WAIT`: entry held, not yet issued.
  - `EX`: entry issued, FU executing.
- `slot_free[i]` = (`EMPTY`) or (`EX` and `fu_done[i]`).
- Dispatch is accepted when `disp_valid`, `slot_free[disp_fu]` and `!branch_miss`. On acceptance:
  - the slot goes to `WAIT` and captures its tags, spec bit and payload;
  - its age is set to 1.
- A tag in `disp_tags` that equals `wb_tag` while `wb_valid` is high is captured as 0.
- A dispatch to a non-free slot is dropped and sets `disp_err`, which is cleared only by reset.
- On `wb_valid`, every `WAIT` source tag equal to `wb_tag` (and nonzero) is cleared at the clock edge.
- Ageing: on each accepted dispatch, every other `WAIT` entry's age increments, saturating at `2^AGE_W-1`.
- An entry is ready when all of the following hold:
  - it is in `WAIT`;
  - all of its tags are 0;
  - `spec` is clear, or its `SPEC_BLOCK` bit is clear.
- Selection:
  - If `!issue_stall`, pick up to `ISSUE_W` ready entries in order of largest age.
  - Equal ages are ordered by lowest slot index.
  - Selected slots go to `WAIT`→`EX`; the age is cleared.
- `EX`→`EMPTY` on `fu_done[i]`, or `EX`→`WAIT` if a dispatch is accepted into slot i in the same cycle. `fu_done` on a slot that is not in `EX` is ignored.
- `branch_miss`:
  - every `WAIT` entry with `spec` set goes to `EMPTY`;
  - `EX` entries are untouched;
  - no selection occurs that cycle;
  - `issue_en` is 0 next cycle.
- `branch_resolved` clears all `spec` bits. If `branch_miss` and `branch_resolved` are both high, the miss wins and no spec bits are cleared first.

## Timing
- Reset values:
  - all slots `EMPTY`;
  - ages, tags and spec bits 0;
  - `issue_en`, `issue_payload` and `disp_err` 0.
- Dispatch sampled at edge t with zero tags: `WAIT` in cycle t+1, selected in t+1, `issue_en` high and state `EX` in cycle t+2.
- Writeback clearing the last tag at edge t: the entry is ready in cycle t+1 (there is no same-cycle bypass), so issue follows at t+2.
- `issue_en` is high for exactly one cycle per issue. With `issue_stall` high, no state changes for selection and `issue_en` is 0.
- Back-to-back: a slot freed by `fu_done` can be re-dispatched in the same cycle.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Structure
- `datapath_pkg` gains:
  - `issue_state_e` (`EMPTY`/`WAIT`/`EX`, 2 bits);
  - the `issue_entry_t` struct (tags, spec, age, payload).
- Sub-module `age_select`: combinational; takes a ready vector and ages, returns up to `ISSUE_W` one-hot grants using iterative max-with-mask.
- Slot storage, tag clearing and the state machines stay in `issue_select`.

## Test plan
- Reset, then dispatch slot 0 with tags 0 → `issue_en` = 5'b00001 two cycles later with the payload echoed; `fu_done[0]` → `slot_state[0]` = `EMPTY`.
- Dispatch slot 1 with tags {3,0,0}, then slot 0 with tags 0, then `wb_tag`=3 → slot 0 issues first; slot 1 issues two cycles after the writeback.
- With `ISSUE_W`=1, make slots 0, 2 and 4 ready in the same cycle with ages 3, 3 and 1 → the issue order is 0, 2, 4 on consecutive cycles.
- Dispatch slot 3 with `spec`=1 and zero tags → it does not issue; assert `branch_resolved` → it issues two cycles later. Repeat the setup with `branch_miss` → slot 3 goes `EMPTY` and never issues.
- Dispatch slot 2 with tag 7 in the same cycle as `wb_valid`/`wb_tag`=7 → the tag is captured as 0 and the entry issues at t+2. Dispatch to a busy slot → `disp_err`=1 and stays set.
- With `ISSUE_W`=2 and `issue_stall` held for 3 cycles with 3 entries ready → no issue during the stall; after release, the two oldest issue together, then the third.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared back-end types: issue slot states, the pending-entry record
// and the writeback tag-match helper.
package datapath_pkg;

  localparam int DP_NUM_FU    = 5;
  localparam int DP_NUM_SRC   = 3;
  localparam int DP_TAG_W     = 5;
  localparam int DP_AGE_W     = 6;
  localparam int DP_PAYLOAD_W = 64;

  localparam int DP_TAGS_W = DP_NUM_SRC * DP_TAG_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    EX    = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [DP_TAGS_W-1:0]    tags;
    logic                    spec;
    logic [DP_AGE_W-1:0]     age;
    logic [DP_PAYLOAD_W-1:0] payload;
  } issue_entry_t;

  // Zero every source tag matched by a live writeback.
  function automatic logic [DP_TAGS_W-1:0] clear_tags(
    input logic [DP_TAGS_W-1:0] tags,
    input logic                 wb_valid,
    input logic [DP_TAG_W-1:0]  wb_tag
  );
    logic [DP_TAGS_W-1:0] r;
    r = tags;
    for (int s = 0; s < DP_NUM_SRC; s++) begin
      if (wb_valid && tags[s*DP_TAG_W +: DP_TAG_W] == wb_tag)
        r[s*DP_TAG_W +: DP_TAG_W] = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/age_select.sv
// Oldest-first grant picker: up to ISSUE_W one-hot grants,
// ties broken toward the lowest slot index.
module age_select #(
  parameter int NUM_FU  = 5,
  parameter int AGE_W   = 6,
  parameter int ISSUE_W = 1
) (
  input  logic [NUM_FU-1:0]            ready,
  input  logic [NUM_FU-1:0][AGE_W-1:0] age,
  output logic [NUM_FU-1:0]            grant
);

  logic [NUM_FU-1:0] avail;
  logic [NUM_FU-1:0] pick;
  logic [AGE_W-1:0]  best_age;
  logic              found;

  always_comb begin
    grant    = '0;
    avail    = ready;
    pick     = '0;
    best_age = '0;
    found    = 1'b0;
    for (int k = 0; k < ISSUE_W; k++) begin
      pick     = '0;
      best_age = '0;
      found    = 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (avail[i] && (!found || age[i] > best_age)) begin
          found    = 1'b1;
          best_age = age[i];
          pick     = '0;
          pick[i]  = 1'b1;
        end
      end
      grant = grant | pick;
      avail = avail & ~pick;
    end
  end

endmodule

// File: rtl/issue_select.sv
// Oldest-first multi-issue scheduler: per-FU pending slots with
// tag wakeup, speculation flush and registered issue outputs.
module issue_select
  import datapath_pkg::*;
#(
  parameter int              NUM_FU     = DP_NUM_FU,
  parameter int              NUM_SRC    = DP_NUM_SRC,
  parameter int              TAG_W      = DP_TAG_W,
  parameter int              AGE_W      = DP_AGE_W,
  parameter int              ISSUE_W    = 1,
  parameter int              PAYLOAD_W  = DP_PAYLOAD_W,
  parameter logic [NUM_FU-1:0] SPEC_BLOCK = 5'b11010
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          disp_valid,
  input  logic [$clog2(NUM_FU)-1:0]     disp_fu,
  input  logic [NUM_SRC*TAG_W-1:0]      disp_tags,
  input  logic                          disp_spec,
  input  logic [PAYLOAD_W-1:0]          disp_payload,
  input  logic                          wb_valid,
  input  logic [TAG_W-1:0]              wb_tag,
  input  logic [NUM_FU-1:0]             fu_done,
  input  logic                          branch_miss,
  input  logic                          branch_resolved,
  input  logic                          issue_stall,
  output logic [NUM_FU-1:0]             slot_free,
  output logic [2*NUM_FU-1:0]           slot_state,
  output logic [NUM_FU-1:0]             issue_en,
  output logic [NUM_FU*PAYLOAD_W-1:0]   issue_payload,
  output logic                          disp_err
);

  localparam int FU_W = $clog2(NUM_FU);

  issue_state_e state [NUM_FU];
  issue_entry_t ent   [NUM_FU];

  logic [NUM_FU-1:0]            sel_hot;
  logic [NUM_FU-1:0]            ready;
  logic [NUM_FU-1:0]            ready_q;
  logic [NUM_FU-1:0]            grant;
  logic [NUM_FU-1:0][AGE_W-1:0] ages;
  logic [NUM_SRC*TAG_W-1:0]     cap_tags;
  logic                         free_sel;
  logic                         acc;
  logic                         err;

  always_comb begin
    slot_free  = '0;
    slot_state = '0;
    sel_hot    = '0;
    ready      = '0;
    ages       = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      sel_hot[i]  = disp_fu == FU_W'(i);
      slot_free[i] = state[i] == EMPTY ||
                     (state[i] == EX && fu_done[i]);
      ready[i] = state[i] == WAIT && ent[i].tags == '0 &&
                 (!ent[i].spec || !SPEC_BLOCK[i]);
      ages[i] = ent[i].age;
      slot_state[2*i +: 2] = state[i];
    end
  end

  assign free_sel = |(sel_hot & slot_free);
  assign acc      = disp_valid && free_sel && !branch_miss;
  assign err      = disp_valid && !free_sel;
  assign cap_tags = clear_tags(disp_tags, wb_valid, wb_tag);
  // A miss cycle issues nothing, so squashed work never reaches EX.
  assign ready_q  = (issue_stall || branch_miss) ? '0 : ready;

  age_select #(
    .NUM_FU (NUM_FU),
    .AGE_W  (AGE_W),
    .ISSUE_W(ISSUE_W)
  ) u_sel (
    .ready(ready_q),
    .age  (ages),
    .grant(grant)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_FU; i++) begin
        state[i] <= EMPTY;
        ent[i]   <= '0;
      end
      issue_en      <= '0;
      issue_payload <= '0;
      disp_err      <= 1'b0;
    end else begin
      if (err) disp_err <= 1'b1;
      issue_en <= grant;
      for (int i = 0; i < NUM_FU; i++) begin
        issue_payload[i*PAYLOAD_W +: PAYLOAD_W] <=
          grant[i] ? ent[i].payload : '0;
        if (acc && sel_hot[i]) begin
          state[i] <= WAIT;
          ent[i]   <= '{tags: cap_tags, spec: disp_spec,
                        age: AGE_W'(1), payload: disp_payload};
        end else begin
          if (branch_resolved && !branch_miss)
            ent[i].spec <= 1'b0;
          unique case (state[i])
            WAIT: begin
              if (branch_miss && ent[i].spec) begin
                state[i] <= EMPTY;
              end else if (grant[i]) begin
                state[i]   <= EX;
                ent[i].age <= '0;
              end else begin
                ent[i].tags <= clear_tags(ent[i].tags,
                                          wb_valid, wb_tag);
                if (acc && ent[i].age != '1)
                  ent[i].age <= ent[i].age + 1'b1;
              end
            end
            EX: begin
              if (fu_done[i]) state[i] <= EMPTY;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
